// File: rtl/axi4_burst_addr_gen.sv
// AXI4 slave burst expander: queues address-phase descriptors and emits one addressed, strobed beat per cycle.
// First beat is presented two edges after a descriptor is accepted; beat outputs hold while beat_ready is low.

module burst_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           wr_vld,
  input  logic [WIDTH-1:0]               wr_dat,
  input  logic                           rd_rdy,
  output logic [WIDTH-1:0]               rd_dat,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + PW'(1);
      if (rd_rdy) rd_ptr <= rd_ptr + PW'(1);
      if (wr_vld && !rd_rdy)
        count <= count + CW'(1);
      else if (!wr_vld && rd_rdy)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
endmodule

module axi4_burst_addr_gen #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 16,
  parameter int LENGTH        = 8,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ID_WIDTH-1:0]              cmd_id,
  input  logic [ADDRESS_WIDTH-1:0]         cmd_addr,
  input  logic [LENGTH-1:0]                cmd_len,
  input  logic [2:0]                       cmd_size,
  input  logic [1:0]                       cmd_burst,
  output logic                             beat_valid,
  input  logic                             beat_ready,
  output logic [ID_WIDTH-1:0]              beat_id,
  output logic [ADDRESS_WIDTH-1:0]         beat_addr,
  output logic [DATA_WIDTH/8-1:0]          beat_strb,
  output logic [LENGTH-1:0]                beat_idx,
  output logic                             beat_last,
  output logic [1:0]                       beat_resp,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);
  localparam int NB     = DATA_WIDTH / 8;
  localparam int LOG2NB = $clog2(NB);
  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b10;
  localparam logic [1:0] B_RSV   = 2'b11;

  typedef struct packed {
    logic [ID_WIDTH-1:0]      id;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [LENGTH-1:0]        len;
    logic [2:0]               size;
    logic [1:0]               burst;
  } desc_t;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t state, state_nxt;
  desc_t  cmd_dat, hd_dat;
  logic   q_full, q_empty, q_push, q_pop;
  logic   load, advance;

  logic [LENGTH-1:0]        act_len;
  logic [2:0]               act_size;
  logic [1:0]               act_mode;
  logic                     act_err;
  logic [ADDRESS_WIDTH-1:0] act_lower, act_upper;

  logic [ADDRESS_WIDTH-1:0] ld_bytes, ld_span, ld_lower, ld_upper;
  logic [12:0]              pg_bytes, pg_off;
  logic [16:0]              pg_span;
  logic [17:0]              pg_end;
  logic                     ld_err;
  logic [1:0]               ld_mode;
  logic [NB-1:0]            ld_strb;

  logic [ADDRESS_WIDTH-1:0] cur_bytes, wrap_step, nxt_addr;
  logic [NB-1:0]            nxt_strb;
  logic [LENGTH-1:0]        idx_nxt;

  // Lanes from the beat's own offset up to the end of its size-aligned container.
  function automatic logic [NB-1:0] strb_calc(input logic [ADDRESS_WIDTH-1:0] a,
                                              input logic [2:0] sz);
    logic [ADDRESS_WIDTH-1:0] bytes;
    logic [ADDRESS_WIDTH-1:0] lane_mask;
    logic [NB-1:0]            s;
    int                       lo;
    int                       hi;
    bytes     = ADDRESS_WIDTH'(1) << sz;
    lane_mask = ADDRESS_WIDTH'(NB - 1);
    lo        = int'(a & lane_mask);
    hi        = int'((a & ~(bytes - ADDRESS_WIDTH'(1))) & lane_mask) + int'(bytes) - 1;
    s         = '0;
    for (int i = 0; i < NB; i++) s[i] = (i >= lo) && (i <= hi);
    return s;
  endfunction

  assign cmd_dat     = '{id: cmd_id, addr: cmd_addr, len: cmd_len, size: cmd_size, burst: cmd_burst};
  assign cmd_ready   = !q_full && !areset;
  assign q_push      = cmd_valid && cmd_ready;
  assign q_pop       = load;
  assign beat_valid  = (state == S_BURST);

  burst_fifo #(
    .WIDTH ($bits(desc_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .aclk   (aclk),
    .areset (areset),
    .wr_vld (q_push),
    .wr_dat (cmd_dat),
    .rd_rdy (q_pop),
    .rd_dat (hd_dat),
    .full   (q_full),
    .empty  (q_empty),
    .count  (queue_count)
  );

  // Load-time decode of the queue head: protocol checks and wrap window.
  always_comb begin
    ld_bytes = ADDRESS_WIDTH'(1) << hd_dat.size;
    ld_span  = (ADDRESS_WIDTH'(hd_dat.len) + ADDRESS_WIDTH'(1)) << hd_dat.size;
    ld_lower = hd_dat.addr & ~(ld_span - ADDRESS_WIDTH'(1));
    ld_upper = ld_lower + ld_span;
    pg_bytes = 13'd1 << hd_dat.size;
    pg_off   = {1'b0, hd_dat.addr[11:0]} & ~(pg_bytes - 13'd1);
    pg_span  = (17'(hd_dat.len) + 17'd1) << hd_dat.size;
    pg_end   = 18'(pg_off) + 18'(pg_span);
    ld_err   = (hd_dat.burst == B_RSV)
            || (32'(hd_dat.size) > 32'(LOG2NB))
            || ((hd_dat.burst == B_WRAP) && (hd_dat.len != LENGTH'(1)) && (hd_dat.len != LENGTH'(3))
                && (hd_dat.len != LENGTH'(7)) && (hd_dat.len != LENGTH'(15)))
            || ((hd_dat.burst == B_WRAP) && ((hd_dat.addr & (ld_bytes - ADDRESS_WIDTH'(1))) != '0))
            || ((hd_dat.burst == B_INCR) && (pg_end > 18'd4096));
    ld_mode  = hd_dat.burst;
    if (ld_err) ld_mode = (hd_dat.burst == B_RSV) ? B_FIXED : B_INCR;
    ld_strb  = ld_err ? '0 : strb_calc(hd_dat.addr, hd_dat.size);
  end

  always_comb begin
    cur_bytes = ADDRESS_WIDTH'(1) << act_size;
    wrap_step = beat_addr + cur_bytes;
    case (act_mode)
      B_FIXED: nxt_addr = beat_addr;
      B_WRAP:  nxt_addr = (wrap_step == act_upper) ? act_lower : wrap_step;
      default: nxt_addr = (beat_addr & ~(cur_bytes - ADDRESS_WIDTH'(1))) + cur_bytes;
    endcase
    nxt_strb = act_err ? '0 : strb_calc(nxt_addr, act_size);
    idx_nxt  = beat_idx + LENGTH'(1);
  end

  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Popping on the last accepted beat gives back-to-back bursts with no idle cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          load      = 1'b1;
          state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (beat_ready) begin
          if (beat_last) begin
            if (!q_empty) load = 1'b1;
            else          state_nxt = S_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_id   <= '0;
      beat_addr <= '0;
      beat_strb <= '0;
      beat_idx  <= '0;
      beat_last <= 1'b0;
      beat_resp <= 2'b00;
      act_len   <= '0;
      act_size  <= '0;
      act_mode  <= B_FIXED;
      act_err   <= 1'b0;
      act_lower <= '0;
      act_upper <= '0;
    end else if (load) begin
      beat_id   <= hd_dat.id;
      beat_addr <= hd_dat.addr;
      beat_strb <= ld_strb;
      beat_idx  <= '0;
      beat_last <= (hd_dat.len == '0);
      beat_resp <= ld_err ? 2'b10 : 2'b00;
      act_len   <= hd_dat.len;
      act_size  <= hd_dat.size;
      act_mode  <= ld_mode;
      act_err   <= ld_err;
      act_lower <= ld_lower;
      act_upper <= ld_upper;
    end else if (advance) begin
      beat_addr <= nxt_addr;
      beat_strb <= nxt_strb;
      beat_idx  <= idx_nxt;
      beat_last <= (idx_nxt == act_len);
    end
  end
endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Scoreboard bench for axi4_burst_addr_gen: directed bursts, error cases, backpressure and mid-burst reset.

module tb_axi4_burst_addr_gen;
  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [15:0] beat_id;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic [1:0]  beat_resp;
  logic [2:0]  queue_count;

  typedef struct {
    logic [15:0] id;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [7:0]  idx;
    logic        last;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  always #5 aclk = ~aclk;

  axi4_burst_addr_gen dut (
    .aclk        (aclk),
    .areset      (areset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_id      (cmd_id),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_size    (cmd_size),
    .cmd_burst   (cmd_burst),
    .beat_valid  (beat_valid),
    .beat_ready  (beat_ready),
    .beat_id     (beat_id),
    .beat_addr   (beat_addr),
    .beat_strb   (beat_strb),
    .beat_idx    (beat_idx),
    .beat_last   (beat_last),
    .beat_resp   (beat_resp),
    .queue_count (queue_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic ex(input logic [15:0] id, input logic [31:0] a, input logic [3:0] s,
                    input logic [7:0] i, input logic l, input logic [1:0] r);
    exp_t e;
    e = '{id, a, s, i, l, r};
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [15:0] id, input logic [31:0] a, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] b);
    bit done;
    done      = 1'b0;
    cmd_id    = id;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_size  = sz;
    cmd_burst = b;
    cmd_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge aclk);
      if (cmd_ready) begin
        @(posedge aclk);
        #1;
        done = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    if (!done) chk("cmd_accept_timeout", 64'(done), 64'(1));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || beat_valid) && n < 400) begin
      @(negedge aclk);
      n++;
    end
    chk(nm, 64'(exp_q.size()), 64'(0));
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_beat_valid"}, 64'(beat_valid), 64'(0));
    chk({tag, "_beat_addr"}, 64'(beat_addr), 64'(0));
    chk({tag, "_beat_strb"}, 64'(beat_strb), 64'(0));
    chk({tag, "_beat_idx"}, 64'(beat_idx), 64'(0));
    chk({tag, "_beat_id"}, 64'(beat_id), 64'(0));
    chk({tag, "_beat_last"}, 64'(beat_last), 64'(0));
    chk({tag, "_beat_resp"}, 64'(beat_resp), 64'(0));
    chk({tag, "_queue_count"}, 64'(queue_count), 64'(0));
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
  endtask

  initial begin
    int nv;
    bit found;
    areset = 1'b1; cmd_valid = 1'b0; beat_ready = 1'b0;
    cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;

    fork
      forever begin
        @(negedge aclk);
        if (!areset && beat_valid && beat_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got beat addr %0h idx %0d, want no beat", beat_addr, beat_idx);
          end else begin
            mon_e = exp_q.pop_front();
            chk("beat_id", 64'(beat_id), 64'(mon_e.id));
            chk("beat_addr", 64'(beat_addr), 64'(mon_e.addr));
            chk("beat_strb", 64'(beat_strb), 64'(mon_e.strb));
            chk("beat_idx", 64'(beat_idx), 64'(mon_e.idx));
            chk("beat_last", 64'(beat_last), 64'(mon_e.last));
            chk("beat_resp", 64'(beat_resp), 64'(mon_e.resp));
          end
        end
      end
    join_none

    repeat (3) @(posedge aclk);
    #1;
    chk_zero("reset");
    areset = 1'b0;
    #1;
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));
    chk("beat_valid_after_reset", 64'(beat_valid), 64'(0));

    // INCR with unaligned start, plus first-beat latency
    beat_ready = 1'b1;
    ex(16'h1, 32'h1002, 4'b1100, 8'd0, 1'b0, 2'b00);
    ex(16'h1, 32'h1004, 4'b1111, 8'd1, 1'b0, 2'b00);
    ex(16'h1, 32'h1008, 4'b1111, 8'd2, 1'b0, 2'b00);
    ex(16'h1, 32'h100C, 4'b1111, 8'd3, 1'b1, 2'b00);
    send(16'h1, 32'h1002, 8'd3, 3'd2, 2'b01);
    chk("lat_valid_n", 64'(beat_valid), 64'(0));
    chk("lat_qcount_n", 64'(queue_count), 64'(1));
    @(posedge aclk);
    #1;
    chk("lat_valid_n1", 64'(beat_valid), 64'(1));
    chk("lat_addr_n1", 64'(beat_addr), 64'h1002);
    drain("drain_incr");

    // WRAP, errored WRAP, FIXED, 4KB crossing, reserved, oversize, len0, bad wrap len
    ex(16'h2, 32'h34, 4'b1111, 8'd0, 1'b0, 2'b00);
    ex(16'h2, 32'h38, 4'b1111, 8'd1, 1'b0, 2'b00);
    ex(16'h2, 32'h3C, 4'b1111, 8'd2, 1'b0, 2'b00);
    ex(16'h2, 32'h30, 4'b1111, 8'd3, 1'b1, 2'b00);
    ex(16'h3, 32'h35, 4'b0000, 8'd0, 1'b0, 2'b10);
    ex(16'h3, 32'h38, 4'b0000, 8'd1, 1'b0, 2'b10);
    ex(16'h3, 32'h3C, 4'b0000, 8'd2, 1'b0, 2'b10);
    ex(16'h3, 32'h40, 4'b0000, 8'd3, 1'b1, 2'b10);
    ex(16'h4, 32'h12, 4'b1100, 8'd0, 1'b0, 2'b00);
    ex(16'h4, 32'h12, 4'b1100, 8'd1, 1'b0, 2'b00);
    ex(16'h4, 32'h12, 4'b1100, 8'd2, 1'b1, 2'b00);
    ex(16'h5, 32'hFF8, 4'b0000, 8'd0, 1'b0, 2'b10);
    ex(16'h5, 32'hFFC, 4'b0000, 8'd1, 1'b0, 2'b10);
    ex(16'h5, 32'h1000, 4'b0000, 8'd2, 1'b0, 2'b10);
    ex(16'h5, 32'h1004, 4'b0000, 8'd3, 1'b1, 2'b10);
    ex(16'h6, 32'h40, 4'b0000, 8'd0, 1'b0, 2'b10);
    ex(16'h6, 32'h40, 4'b0000, 8'd1, 1'b1, 2'b10);
    ex(16'h7, 32'h80, 4'b0000, 8'd0, 1'b0, 2'b10);
    ex(16'h7, 32'h88, 4'b0000, 8'd1, 1'b1, 2'b10);
    ex(16'h8, 32'h100, 4'b0001, 8'd0, 1'b1, 2'b00);
    ex(16'h9, 32'h40, 4'b0000, 8'd0, 1'b0, 2'b10);
    ex(16'h9, 32'h44, 4'b0000, 8'd1, 1'b0, 2'b10);
    ex(16'h9, 32'h48, 4'b0000, 8'd2, 1'b1, 2'b10);
    send(16'h2, 32'h34, 8'd3, 3'd2, 2'b10);
    send(16'h3, 32'h35, 8'd3, 3'd2, 2'b10);
    send(16'h4, 32'h12, 8'd2, 3'd1, 2'b00);
    send(16'h5, 32'hFF8, 8'd3, 3'd2, 2'b01);
    send(16'h6, 32'h40, 8'd1, 3'd2, 2'b11);
    send(16'h7, 32'h80, 8'd1, 3'd3, 2'b01);
    send(16'h8, 32'h100, 8'd0, 3'd0, 2'b01);
    send(16'h9, 32'h40, 8'd2, 3'd2, 2'b10);
    drain("drain_mixed");

    // Backpressure: 5 accepted, 6th refused, then streamed without bubbles
    beat_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ex(16'h10 + 16'(k), 32'h200 + 32'(16 * k), 4'b1111, 8'd0, 1'b0, 2'b00);
      ex(16'h10 + 16'(k), 32'h204 + 32'(16 * k), 4'b1111, 8'd1, 1'b1, 2'b00);
    end
    for (int k = 0; k < 5; k++) send(16'h10 + 16'(k), 32'h200 + 32'(16 * k), 8'd1, 3'd2, 2'b01);
    chk("bp_qcount", 64'(queue_count), 64'(4));
    chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
    cmd_id = 16'h99; cmd_addr = 32'h900; cmd_len = 8'd0; cmd_size = 3'd2; cmd_burst = 2'b01;
    cmd_valid = 1'b1;
    repeat (3) begin
      @(posedge aclk);
      #1;
      chk("stall_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("stall_qcount", 64'(queue_count), 64'(4));
      chk("stall_valid", 64'(beat_valid), 64'(1));
      chk("stall_id", 64'(beat_id), 64'h10);
      chk("stall_addr", 64'(beat_addr), 64'h200);
      chk("stall_strb", 64'(beat_strb), 64'hF);
      chk("stall_idx", 64'(beat_idx), 64'(0));
      chk("stall_last", 64'(beat_last), 64'(0));
    end
    cmd_valid = 1'b0;
    beat_ready = 1'b1;
    nv = 0;
    repeat (10) begin
      @(negedge aclk);
      if (beat_valid) nv++;
    end
    chk("no_bubble_beats", 64'(nv), 64'(10));
    @(negedge aclk);
    chk("bp_idle_after", 64'(beat_valid), 64'(0));
    @(posedge aclk);
    #1;
    drain("drain_bp");

    // Reset on beat 2 of a len-7 burst with two queued behind it
    beat_ready = 1'b0;
    for (int i = 0; i < 3; i++) ex(16'h21, 32'h400 + 32'(4 * i), 4'b1111, 8'(i), 1'b0, 2'b00);
    send(16'h21, 32'h400, 8'd7, 3'd2, 2'b01);
    send(16'h22, 32'h500, 8'd0, 3'd2, 2'b01);
    send(16'h23, 32'h600, 8'd0, 3'd2, 2'b01);
    chk("rst_pre_qcount", 64'(queue_count), 64'(2));
    beat_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge aclk);
      if (beat_valid && beat_idx == 8'd2) found = 1'b1;
    end
    chk("rst_reach_beat2", 64'(found), 64'(1));
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    chk_zero("midrst");
    areset = 1'b0;
    #1;
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("midrst_seen_beats", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    ex(16'h31, 32'h700, 4'b1111, 8'd0, 1'b0, 2'b00);
    ex(16'h31, 32'h704, 4'b1111, 8'd1, 1'b1, 2'b00);
    send(16'h31, 32'h700, 8'd1, 3'd2, 2'b01);
    drain("drain_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
